// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage,
// with a valid/ready handshake whose back-pressure freezes the whole pipeline.
module csa_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NBLK = WIDTH / BLK;

    generate
        if ((WIDTH % BLK) != 0 || BLK < 2 || (BLK % 2) != 0) begin : g_bad_params
            $error("csa_pipe_adder: WIDTH must be a multiple of BLK, BLK even and >= 2");
        end
    endgenerate

    // Level k word: blocks below k already hold finished sum bits, blocks k and up
    // still hold operand A, so the skew and forwarding share one register per level.
    logic [WIDTH-1:0] word_q  [NBLK+1];
    logic [WIDTH-1:0] word_d  [NBLK+1];
    logic [WIDTH-1:0] opb_q   [NBLK];
    logic [WIDTH-1:0] opb_d   [NBLK];
    logic             carry_q [NBLK+1];
    logic             carry_d [NBLK+1];
    logic             valid_q [NBLK+1];
    logic             valid_d [NBLK+1];
    logic             ovf_q;
    logic             ovf_d;
    logic             adv;

    logic [BLK-1:0]   a_blk;
    logic [BLK-1:0]   b_blk;
    logic [BLK:0]     sum0;
    logic [BLK:0]     sum1;
    logic [BLK:0]     sel;

    assign adv      = !valid_q[NBLK] || out_ready;
    assign in_ready = adv;

    always_comb begin
        word_d[0]  = in_a;
        opb_d[0]   = in_sub ? ~in_b : in_b;
        carry_d[0] = in_sub | in_cin;
        valid_d[0] = in_valid;
        a_blk      = '0;
        b_blk      = '0;
        sum0       = '0;
        sum1       = '0;
        sel        = '0;
        for (int k = 0; k < NBLK; k++) begin
            a_blk = word_q[k][k*BLK +: BLK];
            b_blk = opb_q[k][k*BLK +: BLK];
            sum0  = {1'b0, a_blk} + {1'b0, b_blk};
            sum1  = sum0 + {{BLK{1'b0}}, 1'b1};
            sel   = carry_q[k] ? sum1 : sum0;
            word_d[k+1]                 = word_q[k];
            word_d[k+1][k*BLK +: BLK]   = sel[BLK-1:0];
            carry_d[k+1]                = sel[BLK];
            valid_d[k+1]                = valid_q[k];
        end
        for (int k = 1; k < NBLK; k++) begin
            opb_d[k] = opb_q[k-1];
        end
        // After the loop the temporaries hold the top block: carry into the MSB is
        // recovered from its operand and sum bits, then XORed with the carry out.
        ovf_d = a_blk[BLK-1] ^ b_blk[BLK-1] ^ sel[BLK-1] ^ sel[BLK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NBLK; k++) begin
                word_q[k]  <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            for (int k = 0; k < NBLK; k++) begin
                opb_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k <= NBLK; k++) begin
                word_q[k]  <= word_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
            for (int k = 0; k < NBLK; k++) begin
                opb_q[k] <= opb_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[NBLK];
    assign out_sum   = word_q[NBLK];
    assign out_cout  = carry_q[NBLK];
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder (WIDTH=16, BLK=4): directed corner cases, a stalled
// stream, reset with beats in flight and a randomized run against an arithmetic model.
module tb_csa_pipe_adder;
    localparam int W    = 16;
    localparam int B    = 4;
    localparam int NBLK = W / B;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    exp_t exp_q[$];

    csa_pipe_adder #(.WIDTH(W), .BLK(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: full-precision unsigned sum for carry, signed integer result for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W:0]   full;
        longint       sr;
        longint       maxv;
        logic [W-1:0] nb;
        nb   = ~b;
        maxv = (longint'(1) << (W - 1)) - 1;
        if (sub) begin
            full = {1'b0, a} + {1'b0, nb} + (W+1)'(1);
            sr   = longint'($signed(a)) - longint'($signed(b));
        end else begin
            full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (sr > maxv) || (sr < -(maxv + 1));
        return e;
    endfunction

    // Scoreboard and stall-stability monitor, sampling mid-cycle.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            exp_t e;
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_sum", 32'(out_sum), 32'(prev_sum));
                check("hold_flags", {30'd0, out_cout, out_ovf}, {30'd0, prev_cout, prev_ovf});
            end
            if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 32'(out_sum), 32'(e.sum));
                    check("cout", 32'(out_cout), 32'(e.cout));
                    check("ovf", 32'(out_ovf), 32'(e.ovf));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_cout  = out_cout;
            prev_ovf   = out_ovf;
        end
    end

    // Single beat into an idle pipe: checks latency and the explicit expected result.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, input logic [W-1:0] esum, input logic ecout,
                            input logic eovf);
        int lat;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", 32'(lat), 32'(NBLK));
        check("dir_sum", 32'(out_sum), 32'(esum));
        check("dir_flags", {30'd0, out_cout, out_ovf}, {30'd0, ecout, eovf});
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] corner [4];

    function automatic logic [W-1:0] rnd_operand();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    // Streams nbeats; directed mode sends A=B=i with out_ready low over [stall_lo, stall_hi].
    task automatic run_stream(input int nbeats, input bit rnd, input int stall_lo, input int stall_hi);
        int sent = 0;
        int cyc  = 0;
        while ((sent < nbeats || exp_q.size() != 0) && cyc < 3000) begin
            if (sent < nbeats) begin
                if (rnd) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_a     = rnd_operand();
                    in_b     = rnd_operand();
                    in_cin   = 1'($urandom);
                    in_sub   = 1'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_a     = W'(sent);
                    in_b     = W'(sent);
                    in_cin   = 1'b0;
                    in_sub   = 1'b0;
                end
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1 cyc++;
        end
        in_valid = 1'b0;
        check("stream_done", 32'(cyc < 3000), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int out_before;
        corner[0] = '0; corner[1] = '1; corner[2] = 16'h7FFF; corner[3] = 16'h8000;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_flags", {30'd0, out_cout, out_ovf}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_one(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        send_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        out_before = n_out;
        run_stream(8, 1'b0, 6, 9);
        check("stream_count", 32'(n_out - out_before), 32'd8);

        // Reset with three beats in flight; none may reappear after release.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = W'(100 + i); in_b = W'(i); in_cin = 1'b0; in_sub = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_before = n_out;
        repeat (2 * NBLK + 2) @(posedge clk);
        #1;
        check("no_stale_out", 32'(n_out - out_before), 32'd0);

        out_before = n_out;
        run_stream(300, 1'b1, 0, 0);
        check("random_count", 32'(n_out - out_before), 32'd300);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined carry-select adder/subtractor; successor of the combinational carry-select inner block.
- Splits a WIDTH-bit operation into NBLK = WIDTH/BLK blocks. Each block is a pipeline stage: it computes both candidate sums (carry-in 0 and 1) and picks one with the registered carry from the previous stage.
- Adds a valid/ready handshake with back-pressure, a subtract mode, and signed-overflow/carry outputs.
- Sits between operand registers and the datapath result bus. Lets wide adds close timing at one block delay per cycle.

Parameters:
- WIDTH, 32: operand width. Must be a multiple of BLK; checked at elaboration.
- BLK, 8: block width in bits. Even, >= 2.
- NBLK, WIDTH/BLK (derived, localparam): number of stages, which is also the latency.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A, unsigned/two's complement.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in. Ignored when in_sub=1.
- in_sub  in  1  1: A-B; 0: A+B+cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB. For subtract: 1 means no borrow.
- out_ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, all carry/skew registers 0.
- Operand prep at acceptance: B' = in_sub ? ~in_b : in_b. c0 = in_sub ? 1 : in_cin.
- Global advance signal: adv = !out_valid | out_ready. in_ready = adv, combinational; it depends on out_ready.
- Acceptance: a beat is accepted when in_valid & in_ready. When adv=1 every stage shifts one step. Stage 0 loads valid = in_valid. When adv=0 all stages hold, including bubbles.
- Stage k (0..NBLK-1), on adv:
  - s0 = A'[blk k] + B'[blk k] + 0 and s1 = A'[blk k] + B'[blk k] + 1, each BLK+1 bits.
  - The selected block = carry_reg[k] ? s1 : s0.
  - The stage registers the block's sum bits and its carry-out into carry_reg[k+1].
  - carry_reg[0] is c0 captured with the beat.
- Skew: operand blocks k>=1 are delayed through k registers so each stage sees its own beat. Finished low blocks are forwarded alongside the beat to the output register.
- Latency: exactly NBLK cycles from acceptance to out_valid=1, with no stalls. Throughput is 1 beat/cycle.
- Output:
  - out_sum is the concatenated blocks.
  - out_cout is the carry out of block NBLK-1.
  - out_ovf = carry into MSB XOR carry out of MSB. Compute it from the top block's internal carries, registered with the sum.
- Holding: out_* stay stable while out_valid & !out_ready. Result and status bits never change under a stalled valid.
- Bubbles: an invalid beat shifts through as valid=0. Its data is don't-care and must not assert out_valid.
- Simultaneous events: out_valid & out_ready with in_valid in the same cycle gives a full-rate pass with no bubble inserted.
- Reset mid-operation: all in-flight beats are discarded. Nothing is emitted after release until new beats have had NBLK cycles.
- Wrap-around: the sum is mod 2^WIDTH. Carry is reported only through out_cout.

Test Plan:
- WIDTH=16, BLK=4, in_sub=0: A=0x00FF, B=0x0001, cin=0 -> after 4 cycles out_sum=0x0100, out_cout=0, out_ovf=0. Exercises carry across block 1→2.
- Carry ripple, add: A=0xFFFF, B=0x0000, cin=1 -> out_sum=0x0000, out_cout=1, out_ovf=0.
- Signed overflow, add: A=0x7FFF, B=0x0001 -> out_sum=0x8000, out_cout=0, out_ovf=1.
- Subtract: A=0x0005, B=0x0007, in_sub=1, in_cin=1 (in_cin must be ignored) -> out_sum=0xFFFE, out_cout=0, out_ovf=0.
- Subtract overflow: A=0x8000, B=0x0001, in_sub=1 -> out_sum=0x7FFF, out_cout=1, out_ovf=1.
- Back-pressure and reset:
  - Stream 8 back-to-back beats (A=i, B=i for i=0..7) while holding out_ready=0 for cycles 6..9.
  - Expected: in_ready=0 during the stall; outputs held stable; results 0,2,..,14 emitted in order with none lost or duplicated.
  - Then assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately; no stale result appears after release.
